// File: rtl/mage_stream_bridge.sv
// Multi-channel DMA <-> PEA stream bridge with per-channel FWFT FIFOs and a run controller.
// Optional perf counters are enabled with `define MAGE_STREAM_BRIDGE_PERF_EN.
module mage_stream_bridge #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_CH-1:0]          cfg_ch_en_i,
   input  logic [N_CH-1:0]          cfg_ch_dir_i,
   input  logic                     cfg_sync_i,
   input  logic [CNT_W-1:0]         cfg_len_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   input  logic [N_CH-1:0]          dma_valid_i,
   input  logic [N_CH*DATA_W-1:0]   dma_data_i,
   output logic [N_CH-1:0]          dma_ready_o,
   output logic [N_CH-1:0]          dma_valid_o,
   output logic [N_CH*DATA_W-1:0]   dma_data_o,
   input  logic [N_CH-1:0]          dma_ready_i,
   output logic [N_CH-1:0]          pea_valid_o,
   output logic [N_CH*DATA_W-1:0]   pea_data_o,
   input  logic [N_CH-1:0]          pea_ready_i,
   input  logic [N_CH-1:0]          pea_valid_i,
   input  logic [N_CH*DATA_W-1:0]   pea_data_i,
   output logic [N_CH-1:0]          pea_ready_o
`ifdef MAGE_STREAM_BRIDGE_PERF_EN
   ,
   output logic [N_CH*CNT_W-1:0]    perf_stall_o,
   output logic [CNT_W-1:0]         perf_cycles_o
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic [N_CH-1:0]    r_en;
   logic [N_CH-1:0]    r_dir;
   logic               r_sync;
   logic [CNT_W-1:0]   r_len;
   logic [CNT_W-1:0]   r_beats [N_CH];

   logic [DATA_W-1:0]  r_mem  [N_CH][DEPTH];
   logic [AW-1:0]      r_wptr [N_CH];
   logic [AW-1:0]      r_rptr [N_CH];
   logic [OW-1:0]      r_occ  [N_CH];

   logic               w_run;
   logic [N_CH-1:0]    w_in;
   logic [N_CH-1:0]    w_out;
   logic [N_CH-1:0]    w_empty;
   logic [N_CH-1:0]    w_full;
   logic [N_CH-1:0]    w_hit;
   logic [N_CH-1:0]    w_push;
   logic [N_CH-1:0]    w_pop;
   logic               w_all_ne;
   logic               w_sync_rdy;
   logic               w_sync_pop;
   logic               w_fin;
   logic [DATA_W-1:0]  w_din  [N_CH];
   logic [DATA_W-1:0]  w_head [N_CH];
   logic [CNT_W-1:0]   w_beats_nxt [N_CH];

   assign w_run  = (r_state == S_RUN);
   assign w_in   = r_en & ~r_dir;
   assign w_out  = r_en & r_dir;
   assign busy_o = r_busy;
   assign done_o = r_done;

   // Handshake decode; valid/ready derive from registered state only, except the lockstep pop.
   always_comb begin
      dma_ready_o = '0;
      dma_valid_o = '0;
      dma_data_o  = '0;
      pea_valid_o = '0;
      pea_ready_o = '0;
      pea_data_o  = '0;
      w_push      = '0;
      w_pop       = '0;
      w_all_ne    = 1'b1;
      w_sync_rdy  = 1'b1;
      w_fin       = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         w_empty[c]     = (r_occ[c] == '0);
         w_full[c]      = (r_occ[c] == OW'(DEPTH));
         w_hit[c]       = (r_beats[c] == r_len);
         w_head[c]      = r_mem[c][r_rptr[c]];
         w_din[c]       = '0;
         w_beats_nxt[c] = r_beats[c];
         if (w_in[c]) begin
            if (w_empty[c])     w_all_ne   = 1'b0;
            if (!pea_ready_i[c]) w_sync_rdy = 1'b0;
         end
      end
      w_sync_pop = w_run & r_sync & w_all_ne & w_sync_rdy;

      for (int c = 0; c < N_CH; c++) begin
         if (w_in[c]) begin
            dma_ready_o[c] = w_run & ~w_full[c];
            pea_valid_o[c] = w_run & (r_sync ? w_all_ne : ~w_empty[c]);
            w_push[c]      = dma_valid_i[c] & dma_ready_o[c];
            w_pop[c]       = r_sync ? w_sync_pop : (pea_valid_o[c] & pea_ready_i[c]);
            w_din[c]       = dma_data_i[c*DATA_W +: DATA_W];
            if (pea_valid_o[c]) pea_data_o[c*DATA_W +: DATA_W] = w_head[c];
         end else if (w_out[c]) begin
            pea_ready_o[c] = w_run & ~w_full[c] & ~w_hit[c];
            dma_valid_o[c] = w_run & ~w_empty[c] & ~w_hit[c];
            w_push[c]      = pea_valid_i[c] & pea_ready_o[c];
            w_pop[c]       = dma_valid_o[c] & dma_ready_i[c];
            w_din[c]       = pea_data_i[c*DATA_W +: DATA_W];
            if (dma_valid_o[c]) dma_data_o[c*DATA_W +: DATA_W] = w_head[c];
            w_beats_nxt[c] = r_beats[c] + CNT_W'(w_pop[c]);
            if (w_beats_nxt[c] != r_len) w_fin = 1'b0;
         end
      end
   end

   // FIFO storage has no reset; occupancy and pointers define validity.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < N_CH; c++) begin
         if (w_push[c]) r_mem[c][r_wptr[c]] <= w_din[c];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < N_CH; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
            r_occ[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_push[c]) r_wptr[c] <= r_wptr[c] + AW'(1);
            if (w_pop[c])  r_rptr[c] <= r_rptr[c] + AW'(1);
            case ({w_push[c], w_pop[c]})
               2'b10:   r_occ[c] <= r_occ[c] + OW'(1);
               2'b01:   r_occ[c] <= r_occ[c] - OW'(1);
               default: r_occ[c] <= r_occ[c];
            endcase
         end
      end
   end

   // Run controller: config shadowing, beat counters and completion.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_en    <= '0;
         r_dir   <= '0;
         r_sync  <= 1'b0;
         r_len   <= '0;
         for (int c = 0; c < N_CH; c++) r_beats[c] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start_i) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_en    <= cfg_ch_en_i;
                  r_dir   <= cfg_ch_dir_i;
                  r_sync  <= cfg_sync_i;
                  r_len   <= cfg_len_i;
                  for (int c = 0; c < N_CH; c++) r_beats[c] <= '0;
               end
            end
            S_RUN: begin
               for (int c = 0; c < N_CH; c++) r_beats[c] <= w_beats_nxt[c];
               if (w_fin) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MAGE_STREAM_BRIDGE_PERF_EN
   logic [CNT_W-1:0] r_stall [N_CH];
   logic [CNT_W-1:0] r_cycles;

   // Saturating stall/cycle counters, cleared on run entry and frozen outside RUN.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cycles <= '0;
         for (int c = 0; c < N_CH; c++) r_stall[c] <= '0;
      end else if ((r_state == S_IDLE) && start_i) begin
         r_cycles <= '0;
         for (int c = 0; c < N_CH; c++) r_stall[c] <= '0;
      end else if (w_run) begin
         if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
         for (int c = 0; c < N_CH; c++) begin
            if (r_en[c] && w_full[c] && (r_dir[c] ? pea_valid_i[c] : dma_valid_i[c])
                && (r_stall[c] != '1))
               r_stall[c] <= r_stall[c] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      perf_stall_o = '0;
      for (int c = 0; c < N_CH; c++) perf_stall_o[c*CNT_W +: CNT_W] = r_stall[c];
   end
   assign perf_cycles_o = r_cycles;
`endif

endmodule

// File: tb/tb_mage_stream_bridge.sv
// Directed scoreboard bench for mage_stream_bridge (default parameters).
module tb_mage_stream_bridge;

   localparam int unsigned N_CH   = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   logic                   clk_i;
   logic                   rst_i;
   logic [N_CH-1:0]        cfg_ch_en_i, cfg_ch_dir_i;
   logic                   cfg_sync_i;
   logic [CNT_W-1:0]       cfg_len_i;
   logic                   start_i, busy_o, done_o;
   logic [N_CH-1:0]        dma_valid_i, dma_ready_o, dma_valid_o, dma_ready_i;
   logic [N_CH-1:0]        pea_valid_o, pea_ready_i, pea_valid_i, pea_ready_o;
   logic [N_CH*DATA_W-1:0] dma_data_i, dma_data_o, pea_data_o, pea_data_i;
`ifdef MAGE_STREAM_BRIDGE_PERF_EN
   logic [N_CH*CNT_W-1:0]  perf_stall_o;
   logic [CNT_W-1:0]       perf_cycles_o;
`endif

   mage_stream_bridge #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(4), .CNT_W(CNT_W)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_ch_en_i(cfg_ch_en_i), .cfg_ch_dir_i(cfg_ch_dir_i), .cfg_sync_i(cfg_sync_i),
      .cfg_len_i(cfg_len_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .dma_valid_i(dma_valid_i), .dma_data_i(dma_data_i), .dma_ready_o(dma_ready_o),
      .dma_valid_o(dma_valid_o), .dma_data_o(dma_data_o), .dma_ready_i(dma_ready_i),
      .pea_valid_o(pea_valid_o), .pea_data_o(pea_data_o), .pea_ready_i(pea_ready_i),
      .pea_valid_i(pea_valid_i), .pea_data_i(pea_data_i), .pea_ready_o(pea_ready_o)
`ifdef MAGE_STREAM_BRIDGE_PERF_EN
      , .perf_stall_o(perf_stall_o), .perf_cycles_o(perf_cycles_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_done, done_cyc, n_dmapop, n_peapop, last_pop_cyc, first_acc, first_pv;
   logic            lb = 1'b0;
   logic            tb_sync = 1'b0;
   logic [N_CH-1:0] tb_inmask = '0;
   logic [N_CH-1:0] acc_dma, acc_pea;
   logic [DATA_W-1:0] q_pea [N_CH][$];
   logic [DATA_W-1:0] q_dma [N_CH][$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: optional loopback, sample at negedge, score handshakes, return at posedge+1.
   task automatic step();
      logic all_rdy;
      logic [DATA_W-1:0] d;
      if (lb) begin
         pea_valid_i[1] = pea_valid_o[0];
         pea_data_i[DATA_W +: DATA_W] = pea_data_o[0 +: DATA_W];
         pea_ready_i[0] = pea_ready_o[1];
      end
      @(negedge clk_i);
      all_rdy = &(pea_ready_i | ~tb_inmask);
      acc_dma = dma_valid_i & dma_ready_o;
      acc_pea = pea_valid_i & pea_ready_o;
      for (int c = 0; c < N_CH; c++) begin
         if (acc_dma[c]) begin
            d = dma_data_i[c*DATA_W +: DATA_W];
            q_pea[c].push_back(d);
            if (lb && c == 0) q_dma[1].push_back(d);
         end
         if (acc_pea[c] && !lb) q_dma[c].push_back(pea_data_i[c*DATA_W +: DATA_W]);
         if (pea_valid_o[c] && pea_ready_i[c] && (!tb_sync || all_rdy)) begin
            n_peapop++;
            if (q_pea[c].size() == 0) chk("pea_unexpected_beat", 64'(c), 64'(99));
            else chk("pea_data", 64'(pea_data_o[c*DATA_W +: DATA_W]), 64'(q_pea[c].pop_front()));
         end
         if (dma_valid_o[c] && dma_ready_i[c]) begin
            n_dmapop++;
            last_pop_cyc = cyc;
            if (q_dma[c].size() == 0) chk("dma_unexpected_beat", 64'(c), 64'(99));
            else chk("dma_data", 64'(dma_data_o[c*DATA_W +: DATA_W]), 64'(q_dma[c].pop_front()));
         end
      end
      if (first_acc < 0 && acc_dma != '0) first_acc = cyc;
      if (first_pv < 0 && pea_valid_o != '0) first_pv = cyc;
      if (done_o) begin
         n_done++;
         done_cyc = cyc;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   // Start a run, then scramble cfg_* to show the shadow copy is used.
   task automatic start_run(input logic [N_CH-1:0] en, input logic [N_CH-1:0] dir,
                            input logic sync, input logic [CNT_W-1:0] len);
      cfg_ch_en_i = en; cfg_ch_dir_i = dir; cfg_sync_i = sync; cfg_len_i = len;
      tb_sync = sync; tb_inmask = en & ~dir;
      n_done = 0; n_dmapop = 0; n_peapop = 0; first_acc = -1; first_pv = -1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      cfg_ch_en_i = ~en; cfg_ch_dir_i = ~dir; cfg_sync_i = ~sync; cfg_len_i = len + 16'd7;
   endtask

   // Finish a run that uses ch3 as a one-beat output channel.
   task automatic close_run(input string tag);
      dma_ready_i[3] = 1'b1;
      pea_valid_i[3] = 1'b1;
      pea_data_i[3*DATA_W +: DATA_W] = 32'hC105_E000 + DATA_W'(cyc);
      for (int i = 0; i < 20 && n_done == 0; i++) begin
         step();
         if (acc_pea[3]) pea_valid_i[3] = 1'b0;
      end
      pea_valid_i[3] = 1'b0;
      chk(tag, 64'(n_done), 64'(1));
   endtask

   initial begin
      int sent;
      rst_i = 1'b1; start_i = 1'b0;
      cfg_ch_en_i = '0; cfg_ch_dir_i = '0; cfg_sync_i = 1'b0; cfg_len_i = '0;
      dma_valid_i = '0; dma_data_i = '0; dma_ready_i = '0;
      pea_valid_i = '0; pea_data_i = '0; pea_ready_i = '0;
      n_done = 0; done_cyc = 0; n_dmapop = 0; n_peapop = 0;
      last_pop_cyc = 0; first_acc = -1; first_pv = -1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ctrl", 64'({busy_o, done_o, dma_ready_o, dma_valid_o, pea_valid_o, pea_ready_o}), 64'(0));
      chk("rst_data", 64'(|{dma_data_o, pea_data_o}), 64'(0));
      rst_i = 1'b0;
      step();

      // Pass-through: ch0 in, ch1 out, PEA loops ch0 to ch1.
      lb = 1'b1;
      dma_ready_i = '1;
      start_run(4'b0011, 4'b0010, 1'b0, 16'd8);
      chk("t1_busy", 64'(busy_o), 64'(1));
      sent = 0;
      for (int i = 0; i < 60 && n_done == 0; i++) begin
         dma_valid_i[0] = (sent < 8);
         dma_data_i[0 +: DATA_W] = DATA_W'(sent + 1);
         step();
         if (acc_dma[0]) sent++;
      end
      dma_valid_i[0] = 1'b0;
      chk("t1_done_seen", 64'(n_done), 64'(1));
      chk("t1_dma_pops", 64'(n_dmapop), 64'(8));
      chk("t1_done_lat", 64'(done_cyc), 64'(last_pop_cyc + 1));
      chk("t1_pv_lat", 64'(first_pv), 64'(first_acc + 1));
      step();
      chk("t1_done_once", 64'(n_done), 64'(1));
      chk("t1_idle", 64'({busy_o, done_o}), 64'(0));
      lb = 1'b0;
      pea_valid_i = '0; pea_ready_i = '0;

      // Full FIFO: ch0 in with PEA stalled, ch3 keeps the run alive.
      start_run(4'b1001, 4'b1000, 1'b0, 16'd1);
      sent = 0;
      for (int i = 0; i < 10; i++) begin
         dma_valid_i[0] = (sent < 6);
         dma_data_i[0 +: DATA_W] = 32'h100 + DATA_W'(sent);
         step();
         if (acc_dma[0]) sent++;
      end
      chk("t2_accepts", 64'(sent), 64'(4));
      chk("t2_ready_low", 64'(dma_ready_o[0]), 64'(0));
      pea_ready_i[0] = 1'b1;
      for (int i = 0; i < 30 && (sent < 6 || q_pea[0].size() != 0); i++) begin
         dma_valid_i[0] = (sent < 6);
         dma_data_i[0 +: DATA_W] = 32'h100 + DATA_W'(sent);
         step();
         if (acc_dma[0]) sent++;
      end
      dma_valid_i[0] = 1'b0;
      chk("t2_sent", 64'(sent), 64'(6));
      chk("t2_pops", 64'(n_peapop), 64'(6));
      pea_ready_i = '0;
      close_run("t2_done");

      // Lockstep: ch0..2 in, ch2 data arrives 3 cycles late.
      pea_ready_i = 4'b0111;
      start_run(4'b1111, 4'b1000, 1'b1, 16'd1);
      for (int i = 0; i < 6; i++) begin
         if (i < 4)       chk("t3_wait", 64'(pea_valid_o[2:0]), 64'(0));
         else if (i == 4) chk("t3_all", 64'(pea_valid_o[2:0]), 64'(7));
         else             chk("t3_popped", 64'(pea_valid_o[2:0]), 64'(0));
         dma_valid_i[0] = (i == 0);
         dma_valid_i[1] = (i == 0);
         dma_valid_i[2] = (i == 3);
         for (int c = 0; c < 3; c++) dma_data_i[c*DATA_W +: DATA_W] = 32'hA000_0000 + DATA_W'(c);
         step();
      end
      pea_ready_i = 4'b0011;
      dma_valid_i[2:0] = 3'b111;
      for (int c = 0; c < 3; c++) dma_data_i[c*DATA_W +: DATA_W] = 32'hB000_0000 + DATA_W'(c);
      step();
      dma_valid_i = '0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_partial", 64'(pea_valid_o[2:0]), 64'(7));
         step();
      end
      pea_ready_i = 4'b0111;
      step();
      chk("t3_popall", 64'(pea_valid_o[2:0]), 64'(0));
      pea_ready_i = '0;
      close_run("t3_done");

      // Zero length: one RUN cycle, then a single done pulse.
      start_run(4'b0010, 4'b0010, 1'b0, 16'd0);
      chk("t4_run", 64'({busy_o, done_o}), 64'(2));
      step();
      chk("t4_done", 64'({busy_o, done_o}), 64'(1));
      step();
      chk("t4_done_end", 64'({busy_o, done_o}), 64'(0));

      // Start pulse mid-run is ignored.
      start_run(4'b0010, 4'b0010, 1'b0, 16'd3);
      sent = 0;
      for (int i = 0; i < 40 && n_done == 0; i++) begin
         start_i = (i == 2);
         pea_valid_i[1] = (sent < 3);
         pea_data_i[DATA_W +: DATA_W] = 32'h300 + DATA_W'(sent);
         step();
         if (acc_pea[1]) sent++;
      end
      start_i = 1'b0;
      pea_valid_i = '0;
      chk("t4_done_seen", 64'(n_done), 64'(1));
      chk("t4_beats", 64'(n_dmapop), 64'(3));

`ifdef MAGE_STREAM_BRIDGE_PERF_EN
      // Perf: ch1 out fills, then stalls 10 cycles with DMA not ready.
      dma_ready_i = '0;
      start_run(4'b0010, 4'b0010, 1'b0, 16'd4);
      pea_valid_i[1] = 1'b1;
      sent = 0;
      for (int i = 0; i < 14; i++) begin
         pea_data_i[DATA_W +: DATA_W] = 32'h400 + DATA_W'(sent);
         step();
         if (acc_pea[1]) sent++;
      end
      pea_valid_i = '0;
      dma_ready_i = '1;
      for (int i = 0; i < 20 && n_done == 0; i++) step();
      chk("perf_done", 64'(n_done), 64'(1));
      chk("perf_stall", 64'(perf_stall_o[CNT_W +: CNT_W]), 64'(10));
      chk("perf_cycles", 64'(perf_cycles_o), 64'(18));
`endif

      // Reset mid-run with 3 beats buffered in ch0.
      dma_ready_i = '1;
      pea_ready_i = '0;
      start_run(4'b0011, 4'b0010, 1'b0, 16'd8);
      sent = 0;
      for (int i = 0; i < 10 && sent < 3; i++) begin
         dma_valid_i[0] = 1'b1;
         dma_data_i[0 +: DATA_W] = 32'h500 + DATA_W'(sent);
         step();
         if (acc_dma[0]) sent++;
      end
      dma_valid_i = '0;
      chk("t5_buffered", 64'(pea_valid_o[0]), 64'(1));
      #2 rst_i = 1'b1;
      #1;
      chk("t5_rst_ctrl", 64'({busy_o, done_o, dma_ready_o, dma_valid_o, pea_valid_o, pea_ready_o}), 64'(0));
      chk("t5_rst_data", 64'(|{dma_data_o, pea_data_o}), 64'(0));
      q_pea[0].delete();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("t5_busy_low", 64'(busy_o), 64'(0));
      start_run(4'b0011, 4'b0010, 1'b0, 16'd8);
      for (int i = 0; i < 4; i++) begin
         chk("t5_empty", 64'(pea_valid_o[0]), 64'(0));
         step();
      end
      rst_i = 1'b1;
      step();

      for (int c = 0; c < N_CH; c++) begin
         chk("q_pea_empty", 64'(q_pea[c].size()), 64'(0));
         chk("q_dma_empty", 64'(q_dma[c].size()), 64'(0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
